// File: rtl/ddr3_arbiter.sv
// Two-port arbiter in front of a DDR3 controller app interface, with a read-tag FIFO that routes returning data.
// Define DDR3_ARBITER_FIXED_PRIORITY_EN for fixed priority (port 0 wins); the default build is round-robin.
module ddr3_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    calib_done,
    input  logic                    p0_cmd_valid,
    output logic                    p0_cmd_ready,
    input  logic                    p0_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [DATA_WIDTH-1:0]   p0_wdata,
    input  logic [DATA_WIDTH/8-1:0] p0_wmask,
    output logic                    p0_rd_valid,
    output logic [DATA_WIDTH-1:0]   p0_rd_data,
    input  logic                    p1_cmd_valid,
    output logic                    p1_cmd_ready,
    input  logic                    p1_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [DATA_WIDTH-1:0]   p1_wdata,
    input  logic [DATA_WIDTH/8-1:0] p1_wmask,
    output logic                    p1_rd_valid,
    output logic [DATA_WIDTH-1:0]   p1_rd_data,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_rdy,
    input  logic                    app_wdf_rdy,
    input  logic                    app_rd_data_valid,
    input  logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    rd_tag_error
);

    localparam int          MW       = DATA_WIDTH / 8;
    localparam int          PW       = $clog2(TAG_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(TAG_DEPTH);
    localparam logic [2:0]  CMD_WR   = 3'b000;
    localparam logic [2:0]  CMD_RD   = 3'b001;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state_q;
    logic                  port_q;
    logic                  app_en_q;
    logic                  wdf_wren_q;
    logic [2:0]            app_cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MW-1:0]         wmask_q;

    logic                  tag_mem_q [TAG_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW:0]           count_q;
    logic [PW:0]           count_d;
    logic                  tag_err_q;

    logic tag_full, tag_empty, elig0, elig1, grant_any, grant_port;
    logic sel_write, cmd_hs, data_hs, push, pop, head_port;

    // A read is only eligible while the tag FIFO has room for its return tag.
    assign tag_full  = (count_q == FULL_CNT);
    assign tag_empty = (count_q == '0);
    assign elig0     = p0_cmd_valid & (p0_cmd_write | ~tag_full);
    assign elig1     = p1_cmd_valid & (p1_cmd_write | ~tag_full);
    assign grant_any = (state_q == IDLE) & calib_done & (elig0 | elig1);

`ifdef DDR3_ARBITER_FIXED_PRIORITY_EN
    assign grant_port = ~elig0;
`else
    logic last_grant_q;
    assign grant_port = (elig0 & elig1) ? ~last_grant_q : elig1;
`endif

    assign p0_cmd_ready = grant_any & ~grant_port;
    assign p1_cmd_ready = grant_any & grant_port;
    assign sel_write    = grant_port ? p1_cmd_write : p0_cmd_write;

    assign cmd_hs  = app_en_q & app_rdy;
    assign data_hs = wdf_wren_q & app_wdf_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            port_q     <= 1'b0;
            app_en_q   <= 1'b0;
            wdf_wren_q <= 1'b0;
            app_cmd_q  <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
`ifndef DDR3_ARBITER_FIXED_PRIORITY_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        state_q    <= ISSUE;
                        port_q     <= grant_port;
                        app_en_q   <= 1'b1;
                        wdf_wren_q <= sel_write;
                        app_cmd_q  <= sel_write ? CMD_WR : CMD_RD;
                        addr_q     <= grant_port ? p1_addr  : p0_addr;
                        wdata_q    <= grant_port ? p1_wdata : p0_wdata;
                        wmask_q    <= grant_port ? p1_wmask : p0_wmask;
`ifndef DDR3_ARBITER_FIXED_PRIORITY_EN
                        last_grant_q <= grant_port;
`endif
                    end
                end
                ISSUE: begin
                    // Command and data strobes retire independently; leave once neither is pending.
                    if (cmd_hs) app_en_q <= 1'b0;
                    if (data_hs) wdf_wren_q <= 1'b0;
                    if ((cmd_hs | ~app_en_q) & (data_hs | ~wdf_wren_q)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign app_en       = app_en_q;
    assign app_wdf_wren = wdf_wren_q;
    assign app_wdf_end  = wdf_wren_q;
    assign app_cmd      = app_cmd_q;
    assign app_addr     = addr_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = wmask_q;

    // With the FIFO empty, a return that coincides with its own push bypasses straight to the issuing port.
    assign push      = cmd_hs & (app_cmd_q == CMD_RD);
    assign pop       = app_rd_data_valid & (~tag_empty | push);
    assign head_port = tag_empty ? port_q : tag_mem_q[rd_ptr_q];

    assign p0_rd_valid  = pop & ~head_port;
    assign p1_rd_valid  = pop & head_port;
    assign p0_rd_data   = app_rd_data;
    assign p1_rd_data   = app_rd_data;
    assign rd_tag_error = tag_err_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tag_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (app_rd_data_valid & ~pop) tag_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= port_q;
    end

endmodule

// File: tb/tb_ddr3_arbiter.sv
// Randomized scoreboard bench for ddr3_arbiter; the reference model tracks grants, handshakes and read tags from the arbitration rules.
`timescale 1ns/1ps
module tb_ddr3_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;
    localparam int TD = 16;
`ifdef DDR3_ARBITER_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          calib_done = 1'b0;
    logic          p0_cmd_valid = 1'b0, p0_cmd_write = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic [MW-1:0] p0_wmask = '0;
    logic          p1_cmd_valid = 1'b0, p1_cmd_write = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic [MW-1:0] p1_wmask = '0;
    logic          app_rdy = 1'b0, app_wdf_rdy = 1'b0, app_rd_data_valid = 1'b0;
    logic [DW-1:0] app_rd_data = '0;

    logic          p0_cmd_ready, p1_cmd_ready, p0_rd_valid, p1_rd_valid;
    logic [DW-1:0] p0_rd_data, p1_rd_data, app_wdf_data;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_wdf_wren, app_wdf_end, rd_tag_error;
    logic [MW-1:0] app_wdf_mask;

    ddr3_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
        .p0_cmd_valid(p0_cmd_valid), .p0_cmd_ready(p0_cmd_ready), .p0_cmd_write(p0_cmd_write),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
        .p1_cmd_valid(p1_cmd_valid), .p1_cmd_ready(p1_cmd_ready), .p1_cmd_write(p1_cmd_write),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
        .rd_tag_error(rd_tag_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } req_t;

    req_t req_q0[$], req_q1[$], exp_cmd_q[$], exp_wd_q[$];
    int   tag_q[$], rd_seq[$];

    int n_checks = 0, n_errors = 0;
    int cmd_pct = 100, wdf_pct = 100, calib_pct = 100;
    bit rand_gen = 1'b0, ret_en = 1'b1, spurious = 1'b0;
    int ret_pending = 0;
    bit acc0 = 1'b0, acc1 = 1'b0;

    bit   busy = 1'b0, pend_cmd = 1'b0, pend_data = 1'b0, err_m = 1'b0;
    int   last_gnt = 1, cur_port = 0;
    req_t cur, drv_r;
    int   gnt_cnt = 0, gnt1_cnt = 0, rd_gnt0 = 0, wr_gnt1 = 0, en_cyc = 0, wr_cyc = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic req_t mk_req(input bit write);
        req_t r;
        r.write = write;
        r.addr  = AW'($urandom);
        r.data  = {$urandom, $urandom, $urandom, $urandom};
        r.mask  = MW'($urandom);
        return r;
    endfunction

    // Input driver: everything changes 1 ns after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                p0_cmd_valid = 1'b0;
                p1_cmd_valid = 1'b0;
                app_rd_data_valid = 1'b0;
            end else begin
                app_rdy     = ($urandom_range(1, 100) <= cmd_pct);
                app_wdf_rdy = ($urandom_range(1, 100) <= wdf_pct);
                calib_done  = ($urandom_range(1, 100) <= calib_pct);
                if (acc0) begin p0_cmd_valid = 1'b0; acc0 = 1'b0; end
                if (!p0_cmd_valid) begin
                    if (rand_gen && req_q0.size() == 0 && $urandom_range(0, 2) == 0)
                        req_q0.push_back(mk_req($urandom_range(0, 1) == 1));
                    if (req_q0.size() > 0) begin
                        drv_r = req_q0.pop_front();
                        p0_cmd_valid = 1'b1; p0_cmd_write = drv_r.write; p0_addr = drv_r.addr;
                        p0_wdata = drv_r.data; p0_wmask = drv_r.mask;
                    end
                end
                if (acc1) begin p1_cmd_valid = 1'b0; acc1 = 1'b0; end
                if (!p1_cmd_valid) begin
                    if (rand_gen && req_q1.size() == 0 && $urandom_range(0, 2) == 0)
                        req_q1.push_back(mk_req($urandom_range(0, 1) == 1));
                    if (req_q1.size() > 0) begin
                        drv_r = req_q1.pop_front();
                        p1_cmd_valid = 1'b1; p1_cmd_write = drv_r.write; p1_addr = drv_r.addr;
                        p1_wdata = drv_r.data; p1_wmask = drv_r.mask;
                    end
                end
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
                if (spurious) begin
                    app_rd_data_valid = 1'b1;
                    spurious = 1'b0;
                end else if (ret_en && ret_pending > 0 && $urandom_range(0, 1) == 1) begin
                    app_rd_data_valid = 1'b1;
                    ret_pending--;
                end else begin
                    app_rd_data_valid = 1'b0;
                end
            end
        end
    end

    task automatic mon_cycle();
        bit   full, e0, e1, g;
        int   win, p;
        req_t rq;
        full = (tag_q.size() == TD);
        e0 = p0_cmd_valid && (p0_cmd_write || !full);
        e1 = p1_cmd_valid && (p1_cmd_write || !full);
        g = !busy && calib_done && (e0 || e1);
        win = (e0 && e1) ? ((FIXED || last_gnt == 1) ? 0 : 1) : (e0 ? 0 : 1);
        check("p0_cmd_ready", DW'(p0_cmd_ready), DW'(g && win == 0));
        check("p1_cmd_ready", DW'(p1_cmd_ready), DW'(g && win == 1));
        check("app_en", DW'(app_en), DW'(busy && pend_cmd));
        check("app_wdf_wren", DW'(app_wdf_wren), DW'(busy && pend_data));
        check("app_wdf_end", DW'(app_wdf_end), DW'(busy && pend_data));
        if (busy) begin
            check("app_addr_stable", DW'(app_addr), DW'(cur.addr));
            check("app_cmd_stable", DW'(app_cmd), DW'(cur.write ? 3'b000 : 3'b001));
            if (cur.write) begin
                check("wdata_stable", app_wdf_data, cur.data);
                check("wmask_stable", DW'(app_wdf_mask), DW'(cur.mask));
            end
        end
        if (app_en) en_cyc++;
        if (app_wdf_wren) wr_cyc++;
        if (app_en && app_rdy) begin
            if (exp_cmd_q.size() == 0) fail("unexpected_command");
            else begin
                rq = exp_cmd_q.pop_front();
                check("sb_cmd", DW'(app_cmd), DW'(rq.write ? 3'b000 : 3'b001));
                check("sb_addr", DW'(app_addr), DW'(rq.addr));
            end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
            if (exp_wd_q.size() == 0) fail("unexpected_data_beat");
            else begin
                rq = exp_wd_q.pop_front();
                check("sb_wdata", app_wdf_data, rq.data);
                check("sb_wmask", DW'(app_wdf_mask), DW'(rq.mask));
            end
        end
        check("rd_tag_error", DW'(rd_tag_error), DW'(err_m));
        if (app_rd_data_valid && tag_q.size() > 0) begin
            p = tag_q.pop_front();
            check("p0_rd_valid", DW'(p0_rd_valid), DW'(p == 0));
            check("p1_rd_valid", DW'(p1_rd_valid), DW'(p == 1));
            check("rd_data", (p == 0) ? p0_rd_data : p1_rd_data, app_rd_data);
        end else begin
            check("p0_rd_valid_idle", DW'(p0_rd_valid), '0);
            check("p1_rd_valid_idle", DW'(p1_rd_valid), '0);
            if (app_rd_data_valid) err_m = 1'b1;
        end
        if (p0_rd_valid) rd_seq.push_back(0);
        if (p1_rd_valid) rd_seq.push_back(1);
        if (busy) begin
            if (pend_cmd && app_rdy) begin
                pend_cmd = 1'b0;
                if (!cur.write) begin tag_q.push_back(cur_port); ret_pending++; end
            end
            if (pend_data && app_wdf_rdy) pend_data = 1'b0;
            if (!pend_cmd && !pend_data) busy = 1'b0;
        end else if (g) begin
            busy = 1'b1;
            cur_port = win;
            if (win == 1) begin
                cur.write = p1_cmd_write; cur.addr = p1_addr; cur.data = p1_wdata; cur.mask = p1_wmask;
            end else begin
                cur.write = p0_cmd_write; cur.addr = p0_addr; cur.data = p0_wdata; cur.mask = p0_wmask;
            end
            pend_cmd = 1'b1;
            pend_data = cur.write;
            last_gnt = win;
            exp_cmd_q.push_back(cur);
            if (cur.write) exp_wd_q.push_back(cur);
            gnt_cnt++;
            if (win == 1) gnt1_cnt++;
            if (win == 0 && !cur.write) rd_gnt0++;
            if (win == 1 && cur.write) wr_gnt1++;
            if (win == 0) acc0 = 1'b1; else acc1 = 1'b1;
        end
    endtask

    // Monitor: samples on the falling edge, between input changes and the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_app_en", DW'(app_en), '0);
                check("rst_app_wdf_wren", DW'(app_wdf_wren), '0);
                check("rst_app_cmd", DW'(app_cmd), '0);
                check("rst_app_addr", DW'(app_addr), '0);
                check("rst_app_wdf_data", app_wdf_data, '0);
                check("rst_app_wdf_mask", DW'(app_wdf_mask), '0);
                check("rst_rd_tag_error", DW'(rd_tag_error), '0);
                check("rst_p0_rd_valid", DW'(p0_rd_valid), '0);
                check("rst_p1_rd_valid", DW'(p1_rd_valid), '0);
                busy = 1'b0; pend_cmd = 1'b0; pend_data = 1'b0; err_m = 1'b0; last_gnt = 1;
                tag_q.delete(); exp_cmd_q.delete(); exp_wd_q.delete();
                ret_pending = 0; acc0 = 1'b0; acc1 = 1'b0;
            end else begin
                mon_cycle();
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        rand_gen = 1'b0; cmd_pct = 100; wdf_pct = 100; calib_pct = 100; ret_en = 1'b1;
        while (i < 3000 && !(req_q0.size() == 0 && req_q1.size() == 0 && !p0_cmd_valid &&
                             !p1_cmd_valid && !busy && tag_q.size() == 0 && ret_pending == 0)) begin
            tick(1);
            i++;
        end
        if (i >= 3000) fail({name, "_timeout"});
        tick(2);
        check({name, "_cmd_q_empty"}, DW'(exp_cmd_q.size()), '0);
        check({name, "_wd_q_empty"}, DW'(exp_wd_q.size()), '0);
    endtask

    initial begin
        int base, base1, base_en, base_wr, i;
        int exp_seq[3];
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Both ports streaming writes with everything ready.
        for (int k = 0; k < 24; k++) begin
            req_q0.push_back(mk_req(1'b1));
            req_q1.push_back(mk_req(1'b1));
        end
        tick(6);
        base = gnt_cnt; base1 = gnt1_cnt;
        tick(20);
        check("stream_grant_rate", DW'(gnt_cnt - base), DW'(10));
        check("stream_port1_grants", DW'(gnt1_cnt - base1), DW'(FIXED ? 0 : 5));
        req_q0.delete(); req_q1.delete();
        drain("stream");

        // Write data channel stalled for five cycles after the grant.
        wdf_pct = 0;
        base = gnt_cnt; base_en = en_cyc; base_wr = wr_cyc;
        req_q0.push_back(mk_req(1'b1));
        i = 0;
        while (gnt_cnt == base && i < 20) begin tick(1); i++; end
        if (i >= 20) fail("stall_grant_timeout");
        tick(5);
        wdf_pct = 100;
        tick(4);
        check("stall_app_en_cycles", DW'(en_cyc - base_en), DW'(1));
        check("stall_wren_cycles", DW'(wr_cyc - base_wr), DW'(6));
        drain("stall");

        // Interleaved reads from both ports, returned in issue order.
        req_q1.push_back(mk_req(1'b1));
        drain("pre_reads");
        rd_seq.delete();
        req_q0.push_back(mk_req(1'b0));
        req_q0.push_back(mk_req(1'b0));
        req_q1.push_back(mk_req(1'b0));
        drain("reads");
        exp_seq[0] = 0;
        exp_seq[1] = FIXED ? 0 : 1;
        exp_seq[2] = FIXED ? 1 : 0;
        check("read_seq_len", DW'(rd_seq.size()), DW'(3));
        for (int k = 0; k < 3; k++)
            if (k < rd_seq.size()) check("read_seq_port", DW'(rd_seq[k]), DW'(exp_seq[k]));

        // Tag FIFO full: 17 reads with no returns; writes keep flowing.
        ret_en = 1'b0;
        base = rd_gnt0; base1 = wr_gnt1;
        for (int k = 0; k < 17; k++) req_q0.push_back(mk_req(1'b0));
        for (int k = 0; k < 4; k++) req_q1.push_back(mk_req(1'b1));
        tick(60);
        check("full_reads_granted", DW'(rd_gnt0 - base), DW'(16));
        check("full_writes_granted", DW'(wr_gnt1 - base1), DW'(4));
        check("full_17th_waiting", DW'(p0_cmd_valid), DW'(1));
        drain("full");
        check("full_reads_total", DW'(rd_gnt0 - base), DW'(17));

        // Randomized traffic, backpressure and calibration drops.
        rand_gen = 1'b1; cmd_pct = 70; wdf_pct = 60; calib_pct = 85; ret_en = 1'b1;
        tick(3000);
        drain("random");

        // Reset in the middle of a read issue: outstanding reads vanish.
        ret_en = 1'b0;
        base = rd_gnt0;
        for (int k = 0; k < 3; k++) req_q0.push_back(mk_req(1'b0));
        i = 0;
        while (rd_gnt0 - base < 3 && i < 50) begin tick(1); i++; end
        if (i >= 50) fail("midreset_grant_timeout");
        @(posedge clk);
        #2;
        check("midreset_app_en_before", DW'(app_en), DW'(1));
        reset_n = 1'b0;
        req_q0.delete(); req_q1.delete();
        #1;
        check("midreset_app_en_abort", DW'(app_en), '0);
        tick(2);
        reset_n = 1'b1;
        rd_seq.delete();
        ret_en = 1'b1;
        tick(10);
        check("midreset_no_rd_valid", DW'(rd_seq.size()), '0);
        req_q1.push_back(mk_req(1'b0));
        drain("after_reset");
        check("after_reset_read", DW'(rd_seq.size()), DW'(1));

        // Read data with nothing outstanding.
        rd_seq.delete();
        spurious = 1'b1;
        tick(3);
        check("tag_err_set", DW'(rd_tag_error), DW'(1));
        check("tag_err_no_rd_valid", DW'(rd_seq.size()), '0);
        req_q0.push_back(mk_req(1'b1));
        req_q1.push_back(mk_req(1'b0));
        drain("tag_err");
        check("tag_err_sticky", DW'(rd_tag_error), DW'(1));
        reset_n = 1'b0;
        #1;
        check("tag_err_cleared", DW'(rd_tag_error), '0);
        tick(2);
        reset_n = 1'b1;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
